postfix_eval: RTL and testbench

POSTFIX_EVAL -- requirements
Module: postfix_eval

---
 rtl/postfix_eval.sv | 135 +++++++++++++
 tb/tb_postfix_eval.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/postfix_eval.sv
// postfix_eval: stack-based evaluator for single-digit postfix expressions.
// Digits push their value, '+'/'*' pop two operands and push the 8-bit
// result, '=' reports the single remaining stack entry.
module postfix_eval #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tok,
  input  logic       tok_valid,
  output logic       tok_ready,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       ovf,
  output logic       error,
  output logic [4:0] depth
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [2:0] {READY, POP_B, POP_A, EXEC, DONE, ERR} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] stack [DEPTH];
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic [DATA_W-1:0] result_q;
  logic [4:0]        depth_q;
  logic              ovf_q;
  logic              mul_q;

  logic              accept;
  logic              is_digit, is_op, is_eq;
  logic              stack_full;
  logic [AW-1:0]     wr_idx, top_idx;
  logic [DATA_W-1:0] top;
  logic [DATA_W:0]   alu_out;

  // Returns {wrap, value}: wrap set when the full-width result exceeds 8 bits.
  function automatic logic [DATA_W:0] alu(input logic mul,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] full;
    full = mul ? (16'(a) * 16'(b)) : (16'(a) + 16'(b));
    return {|full[2*DATA_W-1:DATA_W], full[DATA_W-1:0]};
  endfunction

  assign accept     = tok_valid && (state == READY);
  assign is_digit   = (tok >= 8'h30) && (tok <= 8'h39);
  assign is_op      = (tok == 8'h2B) || (tok == 8'h2A);
  assign is_eq      = (tok == 8'h3D);
  assign stack_full = (depth_q == 5'(DEPTH));
  assign wr_idx     = depth_q[AW-1:0];
  assign top_idx    = AW'(depth_q - 5'd1);
  assign top        = stack[top_idx];
  assign alu_out    = alu(mul_q, opnd_a, opnd_b);

  assign tok_ready    = (state == READY);
  assign result_valid = (state == DONE);
  assign result       = (state == DONE) ? top : result_q;
  assign ovf          = (state == DONE) && ovf_q;
  assign error        = (state == ERR);
  assign depth        = depth_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= READY;
    else     state <= state_nxt;
  end

  // Next-state decode: tokens are only looked at in READY.
  always_comb begin
    state_nxt = state;
    case (state)
      READY: begin
        if (accept) begin
          if (is_digit)   state_nxt = stack_full ? ERR : READY;
          else if (is_op) state_nxt = (depth_q >= 5'd2) ? POP_B : ERR;
          else if (is_eq) state_nxt = (depth_q == 5'd1) ? DONE : ERR;
          else            state_nxt = ERR;
        end
      end
      POP_B:   state_nxt = POP_A;
      POP_A:   state_nxt = EXEC;
      EXEC:    state_nxt = READY;
      DONE:    state_nxt = READY;
      ERR:     state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  // Stack storage and operand registers; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == READY && accept && is_digit && !stack_full)
      stack[wr_idx] <= tok - 8'h30;
    else if (state == EXEC)
      stack[wr_idx] <= alu_out[DATA_W-1:0];
    if (state == POP_B) opnd_b <= top;
    if (state == POP_A) opnd_a <= top;
  end

  // Occupancy, sticky wrap flag, operator latch and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q  <= 5'd0;
      ovf_q    <= 1'b0;
      mul_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        READY: begin
          if (accept && is_digit && !stack_full) depth_q <= depth_q + 5'd1;
          if (accept && is_op) mul_q <= (tok == 8'h2A);
        end
        POP_B, POP_A: depth_q <= depth_q - 5'd1;
        EXEC: begin
          depth_q <= depth_q + 5'd1;
          if (alu_out[DATA_W]) ovf_q <= 1'b1;
        end
        DONE: begin
          result_q <= top;
          depth_q  <= 5'd0;
          ovf_q    <= 1'b0;
        end
        ERR: begin
          depth_q <= 5'd0;
          ovf_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_postfix_eval.sv
// tb_postfix_eval: directed scenarios for the postfix evaluator.
module tb_postfix_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tok;
  logic       tok_valid;
  logic       tok_ready;
  logic [7:0] result;
  logic       result_valid;
  logic       ovf;
  logic       error;
  logic [4:0] depth;

  int n_cmp  = 0;
  int n_fail = 0;

  postfix_eval #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .tok(tok), .tok_valid(tok_valid),
    .tok_ready(tok_ready), .result(result), .result_valid(result_valid),
    .ovf(ovf), .error(error), .depth(depth)
  );

  always #5 clk = ~clk;

  // Present one token; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] t);
    int waited = 0;
    @(negedge clk);
    while (!tok_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!tok_ready) begin
      n_fail++;
      $display("FAIL ready_timeout tok=%h tok_ready=%b expected 1", t, tok_ready);
    end
    tok = t;
    tok_valid = 1'b1;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tok = 8'h00; tok_valid = 1'b0;
    #3;
    n_cmp++;
    if ({tok_ready, result_valid, ovf, error, depth, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b rv=%b ovf=%b err=%b depth=%0d result=%h expected 1 0 0 0 0 00",
               tok_ready, result_valid, ovf, error, depth, result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    send("3"); send("4");
    n_cmp++;
    if (depth !== 5'd2) begin n_fail++; $display("FAIL add_depth got %0d expected 2", depth); end
    send("+"); send("=");
    n_cmp++;
    if ({result_valid, result, ovf} !== {1'b1, 8'h07, 1'b0}) begin
      n_fail++; $display("FAIL add_result got rv=%b result=%h ovf=%b expected 1 07 0", result_valid, result, ovf);
    end
    step();
    n_cmp++;
    if ({result_valid, depth, result, error} !== {1'b0, 5'd0, 8'h07, 1'b0}) begin
      n_fail++; $display("FAIL add_after got rv=%b depth=%0d result=%h err=%b expected 0 0 07 0", result_valid, depth, result, error);
    end
  endtask

  task automatic test_mixed();
    int cnt;
    send("2"); send("3"); send("4"); send("*");
    cnt = 0;
    while (!tok_ready && cnt < 10) begin step(); cnt++; end
    n_cmp++;
    if (cnt != 3) begin n_fail++; $display("FAIL mul_latency got %0d expected 3", cnt); end
    n_cmp++;
    if (depth !== 5'd2) begin n_fail++; $display("FAIL mixed_depth got %0d expected 2", depth); end
    send("+");
    cnt = 0;
    while (!tok_ready && cnt < 10) begin step(); cnt++; end
    n_cmp++;
    if (cnt != 3) begin n_fail++; $display("FAIL add_latency got %0d expected 3", cnt); end
    send("=");
    n_cmp++;
    if ({result_valid, result, ovf} !== {1'b1, 8'h0E, 1'b0}) begin
      n_fail++; $display("FAIL mixed_result got rv=%b result=%h ovf=%b expected 1 0e 0", result_valid, result, ovf);
    end
    step();
  endtask

  task automatic test_overflow();
    send("9"); send("9"); send("*"); send("9"); send("*"); send("=");
    n_cmp++;
    if ({result_valid, result, ovf} !== {1'b1, 8'hD9, 1'b1}) begin
      n_fail++; $display("FAIL ovf_result got rv=%b result=%h ovf=%b expected 1 d9 1", result_valid, result, ovf);
    end
    step();
    n_cmp++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_low_idle got %b expected 0", ovf); end
    // The wrap flag must not leak into the next expression.
    send("8"); send("1"); send("+"); send("=");
    n_cmp++;
    if ({result_valid, result, ovf} !== {1'b1, 8'h09, 1'b0}) begin
      n_fail++; $display("FAIL ovf_cleared got rv=%b result=%h ovf=%b expected 1 09 0", result_valid, result, ovf);
    end
    step();
  endtask

  task automatic test_errors();
    send("+");
    n_cmp++;
    if ({error, result_valid, depth} !== {1'b1, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL op_empty got err=%b rv=%b depth=%0d expected 1 0 0", error, result_valid, depth);
    end
    step();
    n_cmp++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got %b expected 0", error); end
    send("3"); send("4"); send("=");
    n_cmp++;
    if ({error, result_valid} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL eq_depth2 got err=%b rv=%b expected 1 0", error, result_valid);
    end
    step();
    n_cmp++;
    if ({depth, error} !== {5'd0, 1'b0}) begin
      n_fail++; $display("FAIL eq_depth2_after got depth=%0d err=%b expected 0 0", depth, error);
    end
    send("5"); send("x");
    n_cmp++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL bad_byte got err=%b expected 1", error); end
    step();
    n_cmp++;
    if (depth !== 5'd0) begin n_fail++; $display("FAIL bad_byte_depth got %0d expected 0", depth); end
    // '=' on an empty stack is also malformed.
    send("=");
    n_cmp++;
    if ({error, result_valid} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL eq_empty got err=%b rv=%b expected 1 0", error, result_valid);
    end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) send(8'h31 + 8'(i));
    n_cmp++;
    if ({depth, error} !== {5'd8, 1'b0}) begin
      n_fail++; $display("FAIL full_depth got depth=%0d err=%b expected 8 0", depth, error);
    end
    send("9");
    n_cmp++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL overflow_push got err=%b expected 1", error); end
    step();
    n_cmp++;
    if (depth !== 5'd0) begin n_fail++; $display("FAIL overflow_depth got %0d expected 0", depth); end
  endtask

  task automatic test_back_to_back();
    // Tokens presented while busy must be ignored.
    send("2"); send("3"); send("+");
    tok = "9";
    tok_valid = 1'b1;
    step(); step(); step();
    tok_valid = 1'b0;
    n_cmp++;
    if ({tok_ready, depth} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL busy_ignore got rdy=%b depth=%0d expected 1 1", tok_ready, depth);
    end
    send("=");
    n_cmp++;
    if ({result_valid, result} !== {1'b1, 8'h05}) begin
      n_fail++; $display("FAIL busy_result got rv=%b result=%h expected 1 05", result_valid, result);
    end
    step();
  endtask

  task automatic test_mid_reset();
    send("5"); send("6"); send("*");
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({tok_ready, result_valid, ovf, error, depth, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL midreset_outputs got rdy=%b rv=%b ovf=%b err=%b depth=%0d result=%h expected 1 0 0 0 0 00",
               tok_ready, result_valid, ovf, error, depth, result);
    end
    @(negedge clk);
    rst = 1'b0;
    send("1");
    n_cmp++;
    if ({depth, error, result_valid} !== {5'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL midreset_push got depth=%0d err=%b rv=%b expected 1 0 0", depth, error, result_valid);
    end
    send("=");
    n_cmp++;
    if ({result_valid, result} !== {1'b1, 8'h01}) begin
      n_fail++; $display("FAIL midreset_result got rv=%b result=%h expected 1 01", result_valid, result);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mixed();
    test_overflow();
    test_errors();
    test_full();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
